// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port -- CPU-side front end for the VDP.
//
// Samples an asynchronous 6502-style bus into the clk domain, queues CPU
// writes in a small FIFO and replays them to the VDP as single-cycle strobes
// separated by at least GAP_CYCLES idle cycles. A status register at
// address 3 lets the CPU poll the queue state.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cpu_phi2, cpu_cs_n,   raw CPU bus pins, asynchronous to clk
//   cpu_rw, cpu_addr,
//   cpu_data_in
//   cpu_data_out          registered read data (status at addr 3, else 0)
//   cpu_data_oe           combinational bus drive enable from raw pins
//   vdp_mode, vdp_data    register select / data to the VDP, held between strobes
//   vdp_write             one-cycle write strobe to the VDP
//   irq_n                 low while the FIFO is empty (registered)
module vdp_cpu_port #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_phi2,
  input  logic       cpu_cs_n,
  input  logic       cpu_rw,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_data_in,
  output logic [7:0] cpu_data_out,
  output logic       cpu_data_oe,
  output logic [1:0] vdp_mode,
  output logic       vdp_write,
  output logic [7:0] vdp_data,
  output logic       irq_n
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_GAP} state_t;

  // Bus synchronisers and the held copy of the bus fields.
  logic       phi2_s1_reg, phi2_s2_reg, phi2_s3_reg;
  logic       cs_n_s1_reg, cs_n_s2_reg;
  logic       rw_s1_reg, rw_s2_reg;
  logic [1:0] addr_s1_reg, addr_s2_reg;
  logic [7:0] data_s1_reg, data_s2_reg;
  logic       cs_n_h_reg, rw_h_reg;
  logic [1:0] addr_h_reg;
  logic [7:0] data_h_reg;

  // FIFO state.
  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [3:0]       count_reg;
  logic             overflow_reg;

  // Drain FSM.
  state_t     state_reg, state_next;
  logic [2:0] gap_cnt_reg, gap_cnt_next;
  logic       pop;

  // Output registers.
  logic       vdp_write_reg;
  logic [1:0] vdp_mode_reg;
  logic [7:0] vdp_data_reg;
  logic [7:0] cpu_data_out_reg;
  logic       irq_n_reg;

  logic       bus_event, wr_event, push_req, flush, clr_ovf;
  logic       empty, full, push_ok, ovf_set;
  logic [7:0] status;

  always_ff @(posedge clk) begin
    if (reset) begin
      phi2_s1_reg <= 1'b0;
      phi2_s2_reg <= 1'b0;
      phi2_s3_reg <= 1'b0;
      cs_n_s1_reg <= 1'b0;
      cs_n_s2_reg <= 1'b0;
      rw_s1_reg   <= 1'b0;
      rw_s2_reg   <= 1'b0;
      addr_s1_reg <= 2'd0;
      addr_s2_reg <= 2'd0;
      data_s1_reg <= 8'd0;
      data_s2_reg <= 8'd0;
      cs_n_h_reg  <= 1'b0;
      rw_h_reg    <= 1'b0;
      addr_h_reg  <= 2'd0;
      data_h_reg  <= 8'd0;
    end else begin
      phi2_s1_reg <= cpu_phi2;
      phi2_s2_reg <= phi2_s1_reg;
      phi2_s3_reg <= phi2_s2_reg;
      cs_n_s1_reg <= cpu_cs_n;
      cs_n_s2_reg <= cs_n_s1_reg;
      rw_s1_reg   <= cpu_rw;
      rw_s2_reg   <= rw_s1_reg;
      addr_s1_reg <= cpu_addr;
      addr_s2_reg <= addr_s1_reg;
      data_s1_reg <= cpu_data_in;
      data_s2_reg <= data_s1_reg;
      // Capture while phi2 is high so the falling-edge event uses values
      // that were stable during the CPU's active phase.
      if (phi2_s2_reg) begin
        cs_n_h_reg <= cs_n_s2_reg;
        rw_h_reg   <= rw_s2_reg;
        addr_h_reg <= addr_s2_reg;
        data_h_reg <= data_s2_reg;
      end
    end
  end

  assign bus_event = ~phi2_s2_reg & phi2_s3_reg & ~cs_n_h_reg;
  assign wr_event  = bus_event & ~rw_h_reg;
  assign push_req  = wr_event & (addr_h_reg != 2'd3);
  assign flush     = wr_event & (addr_h_reg == 2'd3);
  assign clr_ovf   = bus_event & rw_h_reg & (addr_h_reg == 2'd3);

  assign empty   = (count_reg == 4'd0);
  assign full    = (count_reg == 4'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign status  = {empty, full, overflow_reg, 1'b0, count_reg};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= {addr_h_reg, data_h_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 4'd0;
    end else if (flush) begin
      // Any pop this cycle still reads the old head; the queue is then empty.
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= 4'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (ovf_set) begin
      overflow_reg <= 1'b1;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      gap_cnt_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // The strobe cycle itself is spent in GAP, and the IDLE cycle before the
  // next pop is also idle, so GAP_CYCLES-1 extra GAP cycles give exactly
  // GAP_CYCLES low cycles between strobes.
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          state_next   = ST_GAP;
          gap_cnt_next = 3'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == 3'd0) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 3'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vdp_write_reg    <= 1'b0;
      vdp_mode_reg     <= 2'd0;
      vdp_data_reg     <= 8'd0;
      cpu_data_out_reg <= 8'h80;
      irq_n_reg        <= 1'b0;
    end else begin
      vdp_write_reg <= pop;
      if (pop) begin
        {vdp_mode_reg, vdp_data_reg} <= fifo_mem[rd_ptr_reg];
      end
      cpu_data_out_reg <= (addr_s2_reg == 2'd3) ? status : 8'h00;
      irq_n_reg        <= ~empty;
    end
  end

  assign cpu_data_oe  = ~cpu_cs_n & cpu_rw & cpu_phi2;
  assign cpu_data_out = cpu_data_out_reg;
  assign vdp_write    = vdp_write_reg;
  assign vdp_mode     = vdp_mode_reg;
  assign vdp_data     = vdp_data_reg;
  assign irq_n        = irq_n_reg;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Testbench for vdp_cpu_port: two instances share the CPU bus pins, one with
// GAP_CYCLES=1 (a) and one with GAP_CYCLES=7 (b). Directed bus cycles with
// hand-computed expectations; strobes are captured by a negedge monitor.
`timescale 1ns/1ps
module tb_vdp_cpu_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_phi2, cpu_cs_n, cpu_rw;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_data_in;

  logic [7:0] cpu_data_out_a, cpu_data_out_b;
  logic       cpu_data_oe_a, cpu_data_oe_b;
  logic [1:0] vdp_mode_a, vdp_mode_b;
  logic       vdp_write_a, vdp_write_b;
  logic [7:0] vdp_data_a, vdp_data_b;
  logic       irq_n_a, irq_n_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall = 0;
  int prev_a = -1;
  int prev_b = -1;

  logic [9:0] pulses_a[$];
  logic [9:0] pulses_b[$];
  int         pulse_cyc_a[$];
  int         pulse_cyc_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vdp_cpu_port #(.FIFO_DEPTH(8), .GAP_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .cpu_phi2(cpu_phi2), .cpu_cs_n(cpu_cs_n),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out_a), .cpu_data_oe(cpu_data_oe_a),
    .vdp_mode(vdp_mode_a), .vdp_write(vdp_write_a), .vdp_data(vdp_data_a),
    .irq_n(irq_n_a)
  );

  vdp_cpu_port #(.FIFO_DEPTH(8), .GAP_CYCLES(7)) u_dut_b (
    .clk(clk), .reset(reset), .cpu_phi2(cpu_phi2), .cpu_cs_n(cpu_cs_n),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out_b), .cpu_data_oe(cpu_data_oe_b),
    .vdp_mode(vdp_mode_b), .vdp_write(vdp_write_b), .vdp_data(vdp_data_b),
    .irq_n(irq_n_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CPU bus cycle: phi2 high for hi clk cycles, then low for lo cycles.
  task automatic bus_cycle(input bit r, input logic [1:0] a, input logic [7:0] d,
                           input int hi, input int lo);
    cpu_cs_n    = 1'b0;
    cpu_rw      = r;
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_phi2    = 1'b1;
    tick(hi);
    cpu_phi2  = 1'b0;
    last_fall = cyc;
    tick(lo);
    cpu_cs_n = 1'b1;
    $display("bus %s addr=%0d data=0x%02h", r ? "rd" : "wr", a, d);
  endtask

  // Strobe monitor; also checks the minimum spacing between strobes.
  always @(negedge clk) begin
    if (reset) begin
      prev_a = -1;
      prev_b = -1;
    end else begin
      if (vdp_write_a) begin
        pulses_a.push_back({vdp_mode_a, vdp_data_a});
        pulse_cyc_a.push_back(cyc);
        if (prev_a >= 0) check_val("gap_a", 32'((cyc - prev_a) >= 2), 32'd1);
        prev_a = cyc;
      end
      if (vdp_write_b) begin
        pulses_b.push_back({vdp_mode_b, vdp_data_b});
        pulse_cyc_b.push_back(cyc);
        if (prev_b >= 0) check_val("gap_b", 32'((cyc - prev_b) >= 8), 32'd1);
        prev_b = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n0, nb0, after;
    logic [9:0] v;
    logic full_seen, ovf_seen, irq_seen;

    cpu_phi2 = 1'b0; cpu_cs_n = 1'b1; cpu_rw = 1'b1;
    cpu_addr = 2'd0; cpu_data_in = 8'h00;
    reset = 1'b1;
    tick(2);
    check_val("rst_dout", 32'(cpu_data_out_a), 32'h80);
    reset = 1'b0;

    // Reset defaults with the status register selected.
    cpu_addr = 2'd3;
    tick(4);
    check_val("rst_write", 32'(vdp_write_a), 32'd0);
    check_val("rst_mode", 32'(vdp_mode_a), 32'd0);
    check_val("rst_data", 32'(vdp_data_a), 32'd0);
    check_val("rst_stat_a", 32'(cpu_data_out_a), 32'h80);
    check_val("rst_stat_b", 32'(cpu_data_out_b), 32'h80);
    check_val("rst_irq", 32'(irq_n_a), 32'd0);

    // Single write: one strobe, 4 clk edges after the raw phi2 fall.
    n0 = pulses_a.size();
    bus_cycle(1'b0, 2'd2, 8'h5A, 2, 2);
    tick(6);
    check_val("single_cnt", 32'(pulses_a.size() - n0), 32'd1);
    v = (pulses_a.size() > n0) ? pulses_a[n0] : 10'h3FF;
    check_val("single_val", 32'(v), 32'h25A);
    check_val("single_lat", 32'((pulses_a.size() > n0) ? pulse_cyc_a[n0] - last_fall : -1), 32'd4);

    // Pacing: 8 back-to-back writes replayed in order, no duplicates.
    n0 = pulses_a.size();
    for (int i = 0; i < 8; i++) bus_cycle(1'b0, 2'd1, 8'(i), 2, 2);
    tick(10);
    check_val("pace_cnt", 32'(pulses_a.size() - n0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      v = (pulses_a.size() > n0 + i) ? pulses_a[n0 + i] : 10'h3FF;
      check_val("pace_val", 32'(v), 32'({2'd1, 8'(i)}));
    end
    check_val("hold_mode", 32'(vdp_mode_a), 32'd1);
    check_val("hold_data", 32'(vdp_data_a), 32'h07);

    // Reads at addr 0..2: data 0, oe follows phi2, no strobes.
    tick(100);
    n0  = pulses_a.size();
    nb0 = pulses_b.size();
    for (int a = 0; a < 3; a++) begin
      cpu_cs_n = 1'b0; cpu_rw = 1'b1; cpu_addr = 2'(a); cpu_phi2 = 1'b1;
      tick(1);
      check_val("oe_hi", 32'(cpu_data_oe_a), 32'd1);
      check_val("oe_hi_b", 32'(cpu_data_oe_b), 32'd1);
      tick(3);
      check_val("rd_dout", 32'(cpu_data_out_a), 32'h00);
      cpu_phi2 = 1'b0;
      tick(1);
      check_val("oe_lo", 32'(cpu_data_oe_a), 32'd0);
      tick(2);
      cpu_cs_n = 1'b1;
      $display("bus rd addr=%0d data=0x%02h", a, cpu_data_out_a);
    end
    cpu_phi2 = 1'b1;
    tick(1);
    check_val("oe_nocs", 32'(cpu_data_oe_a), 32'd0);
    cpu_phi2 = 1'b0;
    tick(10);
    check_val("rd_nowr_a", 32'(pulses_a.size() - n0), 32'd0);
    check_val("rd_nowr_b", 32'(pulses_b.size() - nb0), 32'd0);

    // Flush on the slow instance: at most the in-flight strobe after it.
    nb0 = pulses_b.size();
    for (int i = 0; i < 5; i++) bus_cycle(1'b0, 2'd0, 8'(8'h10 + i), 2, 2);
    bus_cycle(1'b0, 2'd3, 8'h00, 2, 2);
    tick(60);
    after = 0;
    foreach (pulse_cyc_b[i]) if (pulse_cyc_b[i] > last_fall) after++;
    check_val("flush_after", 32'(after <= 1), 32'd1);
    check_val("flush_drop", 32'((pulses_b.size() - nb0) < 5), 32'd1);
    cpu_addr = 2'd3;
    tick(4);
    check_val("flush_stat_b", 32'(cpu_data_out_b), 32'h80);
    check_val("flush_stat_a", 32'(cpu_data_out_a), 32'h80);

    // Overflow: burst of fast writes into the GAP_CYCLES=7 instance.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 23; i++) bus_cycle(1'b0, 2'd1, 8'(i), 2, 2);
    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 2'd1; cpu_data_in = 8'd23;
    cpu_phi2 = 1'b1;
    tick(2);
    cpu_phi2 = 1'b0; cpu_cs_n = 1'b1; cpu_addr = 2'd3;
    $display("bus wr addr=1 data=0x17");
    full_seen = 1'b0; ovf_seen = 1'b0; irq_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      full_seen = full_seen | cpu_data_out_b[6];
      ovf_seen  = ovf_seen | cpu_data_out_b[5];
      irq_seen  = irq_seen | irq_n_b;
    end
    check_val("ovf_full", 32'(full_seen), 32'd1);
    check_val("ovf_flag", 32'(ovf_seen), 32'd1);
    check_val("ovf_irq", 32'(irq_seen), 32'd1);
    check_val("ovf_a_clear", 32'(cpu_data_out_a[5]), 32'd0);

    // Flush keeps the sticky overflow; a status read then clears it.
    bus_cycle(1'b0, 2'd3, 8'h00, 2, 2);
    tick(6);
    check_val("flush_ovf_b", 32'(cpu_data_out_b), 32'hA0);
    check_val("flush_ovf_a", 32'(cpu_data_out_a), 32'h80);
    bus_cycle(1'b1, 2'd3, 8'h00, 2, 2);
    tick(6);
    check_val("ovf_clr_b", 32'(cpu_data_out_b), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
